// File: rtl/key_sched_pkg.sv
// Shared types and helpers for the sequential round-key scheduler.
// Provides the FSM state type, mode encodings and the round-to-word mapping.
package key_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Key word feeding round r: (nw - (r mod nw)) mod nw.
    // nw is a power of two, so this reduces to a negate-and-mask.
    function automatic int unsigned word_index(
        input int unsigned r,
        input int unsigned nw
    );
        return (nw - (r % nw)) % nw;
    endfunction

endpackage

// File: rtl/key_word_sel.sv
// Combinational subkey generator: picks the key word for a round and XORs in the round index.
// Ports: key (NUM_WORDS*WORD_W master key), round (RND_W index) -> subkey (WORD_W).
module key_word_sel
    import key_sched_pkg::*;
#(
    parameter int WORD_W    = 9,
    parameter int NUM_WORDS = 16,
    parameter int RND_W     = 7
) (
    input  logic [NUM_WORDS*WORD_W-1:0] key,
    input  logic [RND_W-1:0]            round,
    output logic [WORD_W-1:0]           subkey
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [WORD_W-1:0] words [NUM_WORDS];
    logic [IDX_W-1:0]  idx;

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_unpack
        assign words[k] = key[k*WORD_W +: WORD_W];
    end

    assign idx    = IDX_W'(word_index(32'(round), NUM_WORDS));
    assign subkey = words[idx] ^ WORD_W'(round);

endmodule

// File: rtl/key_sched_seq.sv
// Sequential round-key scheduler: stores a master key and streams one subkey per round
// over a valid/ready interface, ascending (encrypt) or descending (decrypt).
// Ports: clk, rst (sync, active-high); key_in/mode/key_valid/key_ready load side;
//   abort cancels a schedule; rk_data/rk_round/rk_last/rk_valid/rk_ready stream side.
// Option: define KEY_SCHED_WINDOW_EN to add rk_prev/rk_next (subkeys of round-1 and round+1).
module key_sched_seq
    import key_sched_pkg::*;
#(
    parameter int WORD_W     = 9,
    parameter int NUM_WORDS  = 16,
    parameter int NUM_ROUNDS = 16,
    parameter int RND_W      = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*WORD_W-1:0] key_in,
    input  logic                        mode,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic                        abort,
    output logic [WORD_W-1:0]           rk_data,
    output logic [RND_W-1:0]            rk_round,
    output logic                        rk_last,
    output logic                        rk_valid,
    input  logic                        rk_ready
`ifdef KEY_SCHED_WINDOW_EN
    ,
    output logic [WORD_W-1:0]           rk_prev,
    output logic [WORD_W-1:0]           rk_next
`endif
);

    localparam int KEY_W = NUM_WORDS * WORD_W;

    localparam logic [RND_W-1:0] RND_ONE = RND_W'(1);
    localparam logic [RND_W-1:0] RND_MAX = RND_W'(NUM_ROUNDS);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               mode_q, mode_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [RND_W-1:0]   round_step;
    logic [RND_W-1:0]   round_end;

    // Round after the current one, in the direction of the stored mode.
    assign round_step = (mode_q == MODE_DEC) ? round_q - RND_ONE
                                             : round_q + RND_ONE;
    assign round_end  = (mode_q == MODE_DEC) ? RND_ONE : RND_MAX;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        round_d = round_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = RUN;
                    key_d   = key_in;
                    mode_d  = mode;
                    round_d = (mode == MODE_DEC) ? RND_MAX : RND_ONE;
                    valid_d = 1'b1;
                    last_d  = (NUM_ROUNDS == 1);
                end
            end
            RUN: begin
                // Abort wins over a beat accepted on the same edge.
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (valid_q && rk_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        round_d = round_step;
                        last_d  = (round_step == round_end);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Subkeys are computed from next-state key/round so the registered
    // outputs line up with the presented round; while stalled the
    // inputs are unchanged, which keeps the outputs stable.
    key_word_sel #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .RND_W     (RND_W)
    ) u_sel_cur (
        .key    (key_d),
        .round  (round_d),
        .subkey (data_d)
    );

`ifdef KEY_SCHED_WINDOW_EN
    logic [WORD_W-1:0] prev_q, prev_d;
    logic [WORD_W-1:0] next_q, next_d;
    logic [RND_W-1:0]  round_dn;
    logic [RND_W-1:0]  round_up;

    // Neighbour rounds wrap modulo 2**RND_W.
    assign round_dn = round_d - RND_ONE;
    assign round_up = round_d + RND_ONE;

    key_word_sel #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .RND_W     (RND_W)
    ) u_sel_prev (
        .key    (key_d),
        .round  (round_dn),
        .subkey (prev_d)
    );

    key_word_sel #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .RND_W     (RND_W)
    ) u_sel_next (
        .key    (key_d),
        .round  (round_up),
        .subkey (next_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            next_q <= '0;
        end else begin
            prev_q <= prev_d;
            next_q <= next_d;
        end
    end

    assign rk_prev = prev_q;
    assign rk_next = next_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            mode_q  <= MODE_ENC;
            round_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            round_q <= round_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = valid_q;
    assign rk_round  = round_q;
    assign rk_last   = last_q;
    assign rk_data   = data_q;

endmodule

// File: tb/tb_key_sched_seq.sv
// Scoreboard bench for key_sched_seq with default parameters, key word k = 0x10+k.
// Stimulus queues expected beats; a negedge monitor pops and compares every transferred beat.
module tb_key_sched_seq;

    localparam int WORD_W     = 9;
    localparam int NUM_WORDS  = 16;
    localparam int NUM_ROUNDS = 16;
    localparam int RND_W      = 7;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_WORDS*WORD_W-1:0] key_in;
    logic                        mode;
    logic                        key_valid;
    logic                        key_ready;
    logic                        abort;
    logic [WORD_W-1:0]           rk_data;
    logic [RND_W-1:0]            rk_round;
    logic                        rk_last;
    logic                        rk_valid;
    logic                        rk_ready;
`ifdef KEY_SCHED_WINDOW_EN
    logic [WORD_W-1:0]           rk_prev;
    logic [WORD_W-1:0]           rk_next;
`endif

    key_sched_seq #(
        .WORD_W     (WORD_W),
        .NUM_WORDS  (NUM_WORDS),
        .NUM_ROUNDS (NUM_ROUNDS),
        .RND_W      (RND_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .mode      (mode),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .abort     (abort),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready)
`ifdef KEY_SCHED_WINDOW_EN
        ,
        .rk_prev   (rk_prev),
        .rk_next   (rk_next)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] d;
        logic [RND_W-1:0]  r;
        logic              l;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Word j of the key is 0x10+j; round r uses word (16 - r%16)%16.
    function automatic logic [WORD_W-1:0] sk_model(input int r);
        int j;
        j = (16 - (r % 16)) % 16;
        return WORD_W'(16 + j) ^ WORD_W'(r);
    endfunction

    task automatic push_rounds(input int first, input int n, input bit dec);
        beat_t b;
        int    r;
        for (int i = 0; i < n; i++) begin
            r   = dec ? first - i : first + i;
            b.d = sk_model(r);
            b.r = RND_W'(r);
            b.l = dec ? (r == 1) : (r == NUM_ROUNDS);
            sb.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rk_valid && rk_ready && !abort) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_beat actual_round=%0d expected=none", rk_round);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("sb_data",  32'(rk_data),  32'(e.d));
                chk("sb_round", 32'(rk_round), 32'(e.r));
                chk("sb_last",  32'(rk_last),  32'(e.l));
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic load(input bit m);
        chk("ready_before_load", 32'(key_ready), 32'd1);
        key_valid = 1'b1;
        mode      = m;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (key_ready) break;
            n++;
        end
        chk(name, 32'(key_ready), 32'd1);
        chk("valid_low_idle", 32'(rk_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input int target);
        int n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            if (rk_valid && rk_round == RND_W'(target)) break;
            n++;
        end
        chk("reach_round", 32'(rk_round), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NUM_WORDS; k++)
            key_in[k*WORD_W +: WORD_W] = WORD_W'(16 + k);
        rst       = 1'b1;
        mode      = 1'b0;
        key_valid = 1'b0;
        abort     = 1'b0;
        rk_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key_ready", 32'(key_ready), 32'd1);
        chk("rst_valid",     32'(rk_valid),  32'd0);
        chk("rst_last",      32'(rk_last),   32'd0);
        chk("rst_data",      32'(rk_data),   32'd0);
        chk("rst_round",     32'(rk_round),  32'd0);
        @(posedge clk);
        #1;

        // 1: encrypt, full rate
        push_rounds(1, 16, 1'b0);
        load(1'b0);
        @(negedge clk);
        chk("enc_lat_valid", 32'(rk_valid), 32'd1);
        chk("enc_r1_round",  32'(rk_round), 32'd1);
        chk("enc_r1_data",   32'(rk_data),  32'h1E);
        chk("enc_key_busy",  32'(key_ready), 32'd0);
`ifdef KEY_SCHED_WINDOW_EN
        chk("win_prev", 32'(rk_prev), 32'h10);
        chk("win_next", 32'(rk_next), 32'h1C);
`endif
        wait_idle("enc_done");

        // 2: decrypt, with an ignored key offer mid-run
        push_rounds(16, 16, 1'b1);
        load(1'b1);
        @(negedge clk);
        chk("dec_r16_round", 32'(rk_round), 32'd16);
        chk("dec_r16_data",  32'(rk_data),  32'h00);
        chk("dec_r16_last",  32'(rk_last),  32'd0);
        wait_round(12);
        key_valid = 1'b1;
        mode      = 1'b0;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_idle("dec_done");

        // 3: backpressure at round 5
        push_rounds(1, 16, 1'b0);
        load(1'b0);
        wait_round(5);
        rk_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data",  32'(rk_data),  32'h1E);
            chk("bp_round", 32'(rk_round), 32'd5);
            chk("bp_valid", 32'(rk_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        rk_ready = 1'b1;
        wait_idle("bp_done");

        // 4: abort at round 8 with rk_ready high
        push_rounds(1, 7, 1'b0);
        load(1'b0);
        wait_round(8);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(rk_valid),  32'd0);
        chk("abort_ready", 32'(key_ready), 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ready", 32'(key_ready), 32'd1);
        chk("idle_abort_valid", 32'(rk_valid),  32'd0);
        @(posedge clk);
        #1;
        push_rounds(1, 16, 1'b0);
        load(1'b0);
        @(negedge clk);
        chk("reload_round", 32'(rk_round), 32'd1);
        wait_idle("reload_done");

        // 5: reset mid-schedule
        push_rounds(1, 5, 1'b0);
        load(1'b0);
        wait_round(6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(rk_valid),  32'd0);
        chk("mrst_last",  32'(rk_last),   32'd0);
        chk("mrst_data",  32'(rk_data),   32'd0);
        chk("mrst_round", 32'(rk_round),  32'd0);
        chk("mrst_ready", 32'(key_ready), 32'd1);
        @(posedge clk);
        #1;
        push_rounds(1, 16, 1'b0);
        load(1'b0);
        @(negedge clk);
        chk("mrst_reload_valid", 32'(rk_valid), 32'd1);
        chk("mrst_reload_round", 32'(rk_round), 32'd1);
        wait_idle("mrst_done");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
